conv_tile_scheduler: RTL and testbench

Sequencer for the parallel float16 convolution unit: accepts a tile job (kernel size, weight base, tile count), walks the K×K kernel positions for each output tile, and drives weight-memory reads, window-register load/shift strobes and the unit's active-low run enable. It captures each PARA_X×PARA_Y result vector on the unit's `result_ready` pulse and hands it downstream with a valid/ready handshake. It sits between the layer controller and one convolution unit instance.

---
 rtl/conv_tile_scheduler_pkg.sv | 25 ++
 rtl/conv_tile_scheduler_kernel_pos_counter.sv | 35 +++
 rtl/conv_tile_scheduler.sv | 169 ++++++++++++++++
 tb/tb_conv_tile_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_tile_scheduler_pkg.sv
// Shared parameters, FSM state encoding and kernel-size legality check
// for the convolution tile scheduler.
package conv_tile_scheduler_pkg;

  localparam int DATA_WIDTH        = 16;
  localparam int PARA_X            = 4;
  localparam int PARA_Y            = 4;
  localparam int KERNEL_SIZE_WIDTH = 4;
  localparam int KERNEL_SIZE_MAX   = 5;
  localparam int RESULT_WIDTH      = PARA_X * PARA_Y * DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_MAC,
    ST_WAIT,
    ST_OUT,
    ST_DONE
  } state_t;

  function automatic logic k_illegal(input logic [KERNEL_SIZE_WIDTH-1:0] k);
    return (k == '0) || (k > KERNEL_SIZE_WIDTH'(KERNEL_SIZE_MAX));
  endfunction

endpackage

// File: rtl/conv_tile_scheduler_kernel_pos_counter.sv
// Kernel position counter: walks (r, c) over a K x K window, c fastest,
// and flags the final position so the caller can stop after it.
module kernel_pos_counter
  import conv_tile_scheduler_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         adv,
  input  logic [KERNEL_SIZE_WIDTH-1:0] k,
  output logic [KERNEL_SIZE_WIDTH-1:0] r,
  output logic [KERNEL_SIZE_WIDTH-1:0] c,
  output logic                         last
);

  logic [KERNEL_SIZE_WIDTH-1:0] k_m1;

  assign k_m1 = k - KERNEL_SIZE_WIDTH'(1);
  assign last = (r == k_m1) && (c == k_m1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r <= '0;
      c <= '0;
    end else if (adv) begin
      if (c == k_m1) begin
        c <= '0;
        r <= last ? '0 : r + KERNEL_SIZE_WIDTH'(1);
      end else begin
        c <= c + KERNEL_SIZE_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/conv_tile_scheduler.sv
// Tile job sequencer for one convolution unit: weight reads, window strobes,
// unit run enable and valid/ready handoff of each tile result.
//
// state | meaning
// IDLE  | waiting for start, config latched on accept
// PRIME | first weight read (w_base) issued, unit held in reset
// MAC   | K*K cycles of window strobes, reads run one position ahead
// WAIT  | unit running, waiting for result_ready
// OUT   | result held on out_data until out_ready, unit held in reset
// DONE  | one-cycle done pulse, busy drops afterwards
module conv_tile_scheduler
  import conv_tile_scheduler_pkg::*;
#(
  parameter int WADDR_WIDTH = 8,
  parameter int TILE_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [KERNEL_SIZE_WIDTH-1:0] kernel_size,
  input  logic [WADDR_WIDTH-1:0]       w_base,
  input  logic [TILE_WIDTH-1:0]        tile_count,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         w_rd_en,
  output logic [WADDR_WIDTH-1:0]       w_rd_addr,
  output logic                         row_load,
  output logic                         col_shift,
  output logic [KERNEL_SIZE_WIDTH-1:0] kernel_row,
  output logic                         conv_rst_n,
  input  logic                         conv_result_ready,
  input  logic [RESULT_WIDTH-1:0]      conv_result,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RESULT_WIDTH-1:0]      out_data,
  output logic [TILE_WIDTH-1:0]        out_tile
);

  state_t                       state;
  logic [KERNEL_SIZE_WIDTH-1:0] k_q;
  logic [WADDR_WIDTH-1:0]       w_base_q;
  logic [TILE_WIDTH-1:0]        tile_count_q;
  logic [TILE_WIDTH-1:0]        tile_q;
  logic [TILE_WIDTH-1:0]        tile_next;
  logic                         emitted_last;
  logic [KERNEL_SIZE_WIDTH-1:0] pos_r;
  logic [KERNEL_SIZE_WIDTH-1:0] pos_c;
  logic                         pos_last;
  logic                         cnt_clr;
  logic                         cnt_adv;
  logic [WADDR_WIDTH-1:0]       pos_addr;

  // The counter holds the position to emit on the next edge; PRIME emits (0,0).
  assign cnt_clr   = !(state inside {ST_PRIME, ST_MAC});
  assign cnt_adv   = (state == ST_PRIME) || ((state == ST_MAC) && !emitted_last);
  assign pos_addr  = w_base_q + WADDR_WIDTH'(pos_r) * WADDR_WIDTH'(k_q)
                     + WADDR_WIDTH'(pos_c) + WADDR_WIDTH'(1);
  assign tile_next = tile_q + TILE_WIDTH'(1);

  kernel_pos_counter u_pos (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .adv  (cnt_adv),
    .k    (k_q),
    .r    (pos_r),
    .c    (pos_c),
    .last (pos_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      k_q          <= '0;
      w_base_q     <= '0;
      tile_count_q <= '0;
      tile_q       <= '0;
      emitted_last <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      w_rd_en      <= 1'b0;
      w_rd_addr    <= '0;
      row_load     <= 1'b0;
      col_shift    <= 1'b0;
      kernel_row   <= '0;
      conv_rst_n   <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_tile     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            k_q          <= kernel_size;
            w_base_q     <= w_base;
            tile_count_q <= tile_count;
            tile_q       <= '0;
            busy         <= 1'b1;
            if (k_illegal(kernel_size)) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              err <= 1'b0;
              if (tile_count == '0) begin
                done  <= 1'b1;
                state <= ST_DONE;
              end else begin
                w_rd_en   <= 1'b1;
                w_rd_addr <= w_base;
                state     <= ST_PRIME;
              end
            end
          end
        end
        ST_PRIME, ST_MAC: begin
          if ((state == ST_MAC) && emitted_last) begin
            w_rd_en   <= 1'b0;
            row_load  <= 1'b0;
            col_shift <= 1'b0;
            state     <= ST_WAIT;
          end else begin
            conv_rst_n   <= 1'b1;
            row_load     <= (pos_c == '0);
            col_shift    <= (pos_c != '0);
            kernel_row   <= pos_r;
            // The final position's weight was already fetched one cycle earlier.
            w_rd_en      <= !pos_last;
            if (!pos_last) w_rd_addr <= pos_addr;
            emitted_last <= pos_last;
            state        <= ST_MAC;
          end
        end
        ST_WAIT: begin
          if (conv_result_ready) begin
            out_data   <= conv_result;
            out_tile   <= tile_q;
            out_valid  <= 1'b1;
            conv_rst_n <= 1'b0;
            state      <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            tile_q    <= tile_next;
            if (tile_next == tile_count_q) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              w_rd_en   <= 1'b1;
              w_rd_addr <= w_base_q;
              state     <= ST_PRIME;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Scoreboard bench for conv_tile_scheduler with a simple convolution unit model.
module tb_conv_tile_scheduler;
  import conv_tile_scheduler_pkg::*;

  localparam int RW = RESULT_WIDTH;
  localparam int MODEL_DELAY = 10;

  typedef struct {
    logic [RW-1:0] data;
    logic [7:0]    tile;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    kernel_size = '0;
  logic [7:0]    w_base = '0;
  logic [7:0]    tile_count = '0;
  logic          busy, done, err, w_rd_en, row_load, col_shift, conv_rst_n, out_valid;
  logic [7:0]    w_rd_addr, out_tile;
  logic [3:0]    kernel_row;
  logic          conv_result_ready = 1'b0;
  logic [RW-1:0] conv_result = '0;
  logic          out_ready = 1'b1;
  logic [RW-1:0] out_data;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0, rl_cnt = 0, cs_cnt = 0, hs_cnt = 0;
  int cur_k = 1;
  int model_tile = 0;
  int run_cnt = 0;
  logic [RW-1:0] mdata;
  logic [7:0] exp_addr[$];
  exp_t exp_out[$];

  conv_tile_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .kernel_size       (kernel_size),
    .w_base            (w_base),
    .tile_count        (tile_count),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .w_rd_en           (w_rd_en),
    .w_rd_addr         (w_rd_addr),
    .row_load          (row_load),
    .col_shift         (col_shift),
    .kernel_row        (kernel_row),
    .conv_rst_n        (conv_rst_n),
    .conv_result_ready (conv_result_ready),
    .conv_result       (conv_result),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_tile          (out_tile)
  );

  always #5 clk = ~clk;

  // Unit model: one result pulse MODEL_DELAY cycles after run enable rises.
  always @(posedge clk) begin
    if (rst || !conv_rst_n) begin
      run_cnt           <= 0;
      conv_result_ready <= 1'b0;
    end else begin
      run_cnt <= run_cnt + 1;
      if (run_cnt == MODEL_DELAY) begin
        for (int i = 0; i < RW / 32; i++) mdata[i*32 +: 32] = $urandom;
        conv_result       <= mdata;
        conv_result_ready <= 1'b1;
        exp_out.push_back('{data: mdata, tile: 8'(model_tile)});
        model_tile = model_tile + 1;
      end else begin
        conv_result_ready <= 1'b0;
      end
    end
  end

  // Monitor: read addresses and delivered tiles against the scoreboard.
  always @(negedge clk) begin
    logic [7:0] ea;
    exp_t eo;
    if (!rst) begin
      if (w_rd_en) begin
        rd_cnt++;
        checks++;
        if (exp_addr.size() == 0) begin
          errors++;
          $display("FAIL rd_addr: unexpected read of %02h, none expected", w_rd_addr);
        end else begin
          ea = exp_addr.pop_front();
          if (w_rd_addr !== ea) begin
            errors++;
            $display("FAIL rd_addr: got %02h expected %02h", w_rd_addr, ea);
          end
        end
      end
      if (row_load) begin
        checks++;
        if (kernel_row !== 4'(rl_cnt % cur_k)) begin
          errors++;
          $display("FAIL kernel_row: got %0d expected %0d", kernel_row, rl_cnt % cur_k);
        end
        rl_cnt++;
      end
      if (col_shift) cs_cnt++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        checks++;
        if (exp_out.size() == 0) begin
          errors++;
          $display("FAIL out_hs: unexpected output tile %0d", out_tile);
        end else begin
          eo = exp_out.pop_front();
          if (out_data !== eo.data || out_tile !== eo.tile) begin
            errors++;
            $display("FAIL out_data: got tile %0d data %h expected tile %0d data %h",
                     out_tile, out_data[63:0], eo.tile, eo.data[63:0]);
          end
        end
      end
    end
  end

  task automatic start_job(input logic [3:0] k, input logic [7:0] base, input logic [7:0] tc);
    rd_cnt = 0; rl_cnt = 0; cs_cnt = 0; hs_cnt = 0;
    cur_k = (k == 0) ? 1 : int'(k);
    model_tile = 0;
    exp_addr.delete();
    if (k >= 1 && k <= 5)
      for (int t = 0; t < int'(tc); t++)
        for (int i = 0; i < int'(k) * int'(k); i++) exp_addr.push_back(8'(int'(base) + i));
    @(posedge clk); #1;
    start = 1'b1; kernel_size = k; w_base = base; tile_count = tc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < maxc);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", maxc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, err, w_rd_en, row_load, col_shift, out_valid, conv_rst_n} !== 8'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {busy, done, err, w_rd_en, row_load, col_shift, out_valid, conv_rst_n});
    end
    checks++;
    if (w_rd_addr !== 8'h00 || kernel_row !== 4'h0 || out_tile !== 8'h00 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_values: addr %02h row %0d tile %0d expected all zero",
               w_rd_addr, kernel_row, out_tile);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    out_ready = 1'b1;
    start_job(4'd3, 8'h10, 8'd2);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    wait_done(400, n);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", err); end
    checks++;
    if (rd_cnt != 18 || rl_cnt != 6 || cs_cnt != 12 || hs_cnt != 2) begin
      errors++;
      $display("FAIL basic_counts: rd %0d rl %0d cs %0d hs %0d expected 18 6 12 2",
               rd_cnt, rl_cnt, cs_cnt, hs_cnt);
    end
    checks++;
    if (exp_addr.size() != 0 || exp_out.size() != 0) begin
      errors++;
      $display("FAIL basic_drain: addr left %0d out left %0d expected 0 0",
               exp_addr.size(), exp_out.size());
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: done %b busy %b expected 0 0", done, busy);
    end
  endtask

  task automatic test_illegal_k();
    logic [3:0] bad_k [3] = '{4'd6, 4'd0, 4'd15};
    int n;
    for (int j = 0; j < 3; j++) begin
      start_job(bad_k[j], 8'h40, 8'd3);
      wait_done(5, n);
      checks++;
      if (n > 2 || err !== 1'b1 || rd_cnt != 0) begin
        errors++;
        $display("FAIL illegal_k%0d: latency %0d err %b reads %0d expected <=2 1 0",
                 bad_k[j], n, err, rd_cnt);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || err !== 1'b1) begin
        errors++;
        $display("FAIL illegal_after: busy %b err %b expected 0 1", busy, err);
      end
    end
  endtask

  task automatic test_zero_tiles();
    int n;
    start_job(4'd3, 8'h50, 8'd0);
    wait_done(5, n);
    checks++;
    if (err !== 1'b0 || rd_cnt != 0 || hs_cnt != 0 || rl_cnt != 0) begin
      errors++;
      $display("FAIL zero_tiles: err %b reads %0d outs %0d loads %0d expected 0 0 0 0",
               err, rd_cnt, hs_cnt, rl_cnt);
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [RW-1:0] d0;
    out_ready = 1'b0;
    start_job(4'd3, 8'h20, 8'd2);
    n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (!out_valid) begin errors++; $display("FAIL bp_valid_timeout: out_valid never rose"); end
    d0 = out_data;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== d0 || conv_rst_n !== 1'b0 || out_tile !== 8'd0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid %b stable %b conv_rst_n %b tile %0d expected 1 1 0 0",
                 i, out_valid, out_data === d0, conv_rst_n, out_tile);
      end
    end
    checks++;
    if (hs_cnt != 0 || exp_out.size() != 1) begin
      errors++;
      $display("FAIL bp_no_advance: outs %0d pending %0d expected 0 1", hs_cnt, exp_out.size());
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(400, n);
    checks++;
    if (hs_cnt != 2 || exp_out.size() != 0 || rd_cnt != 18) begin
      errors++;
      $display("FAIL bp_final: outs %0d pending %0d reads %0d expected 2 0 18",
               hs_cnt, exp_out.size(), rd_cnt);
    end
  endtask

  task automatic test_wrap();
    int n;
    start_job(4'd3, 8'hFC, 8'd1);
    wait_done(200, n);
    checks++;
    if (rd_cnt != 9 || exp_addr.size() != 0 || hs_cnt != 1) begin
      errors++;
      $display("FAIL wrap: reads %0d addr left %0d outs %0d expected 9 0 1",
               rd_cnt, exp_addr.size(), hs_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    start_job(4'd3, 8'h30, 8'd2);
    n = 0;
    while (hs_cnt < 1 && n < 300) begin @(negedge clk); n++; end
    while (!row_load && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (!row_load) begin errors++; $display("FAIL mid_timeout: tile 1 MAC not reached"); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, err, w_rd_en, row_load, col_shift, out_valid, conv_rst_n} !== 8'b0 ||
        w_rd_addr !== 8'h00 || kernel_row !== 4'h0 || out_tile !== 8'h00 || out_data !== '0) begin
      errors++;
      $display("FAIL mid_reset: flags %b addr %02h tile %0d expected all zero",
               {busy, done, err, w_rd_en, row_load, col_shift, out_valid, conv_rst_n},
               w_rd_addr, out_tile);
    end
    exp_out.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    start_job(4'd1, 8'h55, 8'd1);
    wait_done(100, n);
    checks++;
    if (rd_cnt != 1 || rl_cnt != 1 || cs_cnt != 0 || hs_cnt != 1 || err !== 1'b0 ||
        exp_addr.size() != 0 || exp_out.size() != 0) begin
      errors++;
      $display("FAIL k1_after_reset: rd %0d rl %0d cs %0d outs %0d err %b expected 1 1 0 1 0",
               rd_cnt, rl_cnt, cs_cnt, hs_cnt, err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal_k();
    test_zero_tiles();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
